// File: rtl/coherence_bus_ctrl.sv
// Bus/coherence controller: arbitrates icache/dcache pairs onto one RAM port and runs MSI snooping.
// Optional feature macro CC_FWD_EN: forward dirty flush data straight to the requester during the RAM write.
module coherence_bus_ctrl #(
    parameter int CPUS = 2
) (
    input  logic                   i_CLK,
    input  logic                   i_nRST,
    input  logic [CPUS-1:0]        i_iREN,
    input  logic [CPUS-1:0]        i_dREN,
    input  logic [CPUS-1:0]        i_dWEN,
    input  logic [CPUS-1:0][31:0]  i_iaddr,
    input  logic [CPUS-1:0][31:0]  i_daddr,
    input  logic [CPUS-1:0][31:0]  i_dstore,
    input  logic [CPUS-1:0]        i_ccwrite,
    input  logic [CPUS-1:0]        i_cctrans,
    input  logic [31:0]            i_ramload,
    input  logic [1:0]             i_ramstate,
    output logic [CPUS-1:0]        o_iwait,
    output logic [CPUS-1:0]        o_dwait,
    output logic [CPUS-1:0][31:0]  o_iload,
    output logic [CPUS-1:0][31:0]  o_dload,
    output logic [31:0]            o_ramaddr,
    output logic [31:0]            o_ramstore,
    output logic                   o_ramREN,
    output logic                   o_ramWEN,
    output logic [CPUS-1:0]        o_ccwait,
    output logic [CPUS-1:0]        o_ccinv,
    output logic [CPUS-1:0][31:0]  o_ccsnoopaddr
);

    localparam int         IW         = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [1:0] RAM_ACCESS = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IFETCH,
        S_DWB,
        S_SNOOP,
        S_FWD,
        S_DRD,
        S_INV
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_gnt, r_rr, w_gnt_nxt, w_rr_nxt, w_pick, w_oth;
    logic            r_lock, w_lock_nxt;
    logic            w_found, w_acc, w_done;
    logic [CPUS-1:0] w_req;

    assign w_req = i_iREN | i_dREN | i_dWEN | (i_cctrans & i_ccwrite);
    assign w_acc = (i_ramstate == RAM_ACCESS);
    assign w_oth = IW'((int'(r_gnt) + 1) % CPUS);

    always_ff @(posedge i_CLK) begin
        if (!i_nRST) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_rr    <= '0;
            r_lock  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_rr    <= w_rr_nxt;
            r_lock  <= w_lock_nxt;
        end
    end

    // Round-robin scan from r_rr; a locked block restricts the grant to the previous owner.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr;
        for (int k = 0; k < CPUS; k++) begin
            if (!w_found && w_req[IW'((int'(r_rr) + k) % CPUS)]) begin
                w_found = 1'b1;
                w_pick  = IW'((int'(r_rr) + k) % CPUS);
            end
        end
        if (r_lock) begin
            w_found = w_req[r_gnt];
            w_pick  = r_gnt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_rr_nxt      = r_rr;
        w_lock_nxt    = r_lock;
        w_done        = 1'b0;
        o_iwait       = '1;
        o_dwait       = '1;
        o_iload       = '0;
        o_dload       = '0;
        o_ramaddr     = '0;
        o_ramstore    = '0;
        o_ramREN      = 1'b0;
        o_ramWEN      = 1'b0;
        o_ccwait      = '0;
        o_ccinv       = '0;
        o_ccsnoopaddr = '0;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt  = w_pick;
                    w_lock_nxt = 1'b0;
                    if (i_dWEN[w_pick])
                        w_state_nxt = S_DWB;
                    else if (i_dREN[w_pick] && i_cctrans[w_pick])
                        w_state_nxt = (CPUS > 1) ? S_SNOOP : S_DRD;
                    else if (i_cctrans[w_pick] && i_ccwrite[w_pick] && !i_dREN[w_pick])
                        w_state_nxt = S_INV;
                    else if (i_dREN[w_pick])
                        w_state_nxt = S_DRD;
                    else
                        w_state_nxt = S_IFETCH;
                end else if (r_lock && !i_cctrans[r_gnt]) begin
                    w_lock_nxt = 1'b0;
                    w_rr_nxt   = w_oth;
                end
            end
            S_IFETCH: begin
                o_ramREN  = 1'b1;
                o_ramaddr = i_iaddr[r_gnt];
                if (w_acc) begin
                    o_iload[r_gnt] = i_ramload;
                    o_iwait[r_gnt] = 1'b0;
                    w_done         = 1'b1;
                end
            end
            S_DWB: begin
                o_ramWEN   = 1'b1;
                o_ramaddr  = i_daddr[r_gnt];
                o_ramstore = i_dstore[r_gnt];
                if (w_acc) begin
                    o_dwait[r_gnt] = 1'b0;
                    w_done         = 1'b1;
                end
            end
            S_DRD: begin
                o_ramREN  = 1'b1;
                o_ramaddr = i_daddr[r_gnt];
                if (w_acc) begin
                    o_dload[r_gnt] = i_ramload;
                    o_dwait[r_gnt] = 1'b0;
                    w_done         = 1'b1;
                end
            end
            S_SNOOP: begin
                if (CPUS > 1) begin
                    o_ccwait[w_oth]      = 1'b1;
                    o_ccsnoopaddr[w_oth] = i_daddr[r_gnt];
                    o_ccinv[w_oth]       = i_ccwrite[r_gnt];
                    if (i_cctrans[w_oth])
                        w_state_nxt = i_dWEN[w_oth] ? S_FWD : S_DRD;
                end
            end
            S_FWD: begin
                o_ccwait[w_oth] = 1'b1;
                o_ramWEN        = 1'b1;
                o_ramaddr       = i_daddr[w_oth];
                o_ramstore      = i_dstore[w_oth];
                if (w_acc) begin
                    o_dwait[w_oth] = 1'b0;
`ifdef CC_FWD_EN
                    o_dload[r_gnt] = i_dstore[w_oth];
                    o_dwait[r_gnt] = 1'b0;
                    w_done         = 1'b1;
`else
                    // Requester rereads the freshly flushed word from RAM.
                    w_state_nxt    = S_DRD;
`endif
                end
            end
            S_INV: begin
                if (CPUS > 1) begin
                    o_ccwait[w_oth]      = 1'b1;
                    o_ccinv[w_oth]       = 1'b1;
                    o_ccsnoopaddr[w_oth] = i_daddr[r_gnt];
                end
                o_dwait[r_gnt] = 1'b0;
                w_done         = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Holding cctrans keeps the bus for the second word of the block.
        if (w_done) begin
            w_state_nxt = S_IDLE;
            if (i_cctrans[r_gnt])
                w_lock_nxt = 1'b1;
            else
                w_rr_nxt = w_oth;
        end
    end

endmodule
